axi_write_slave: RTL

//  AXI3 write-channel responder (slave). Accepts AW/W bursts from an AXI master and drives a

---
 rtl/axi_write_slave_if.sv | 40 ++++
 rtl/axi_write_slave.sv | 74 +++++++
 2 files changed

// File: rtl/axi_write_slave_if.sv
// axi_write_slave_if: AXI3 AW/W/B channels plus the RAM write port of axi_write_slave.
interface axi_write_slave_if #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 32
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_sel;
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid, ram_we, ram_addr, ram_wdata, ram_sel
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid, ram_we, ram_addr, ram_wdata, ram_sel
  );
endinterface

// File: rtl/axi_write_slave.sv
// axi_write_slave: single-outstanding AXI3 write responder driving a one-cycle RAM write port.
// Define AXI_WR_SLAVE_ERR_CHECK_EN to enable awsize/wid/wlast checking with SLVERR responses.
module axi_write_slave #(
  parameter int ID_W = 4,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic reset,
  axi_write_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t            state_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, cnt_q, cnt_d;
  logic [1:0]        burst_q;
  logic              err_q, aw_err, beat_err, aw_hs, w_hs, b_hs, last;
  logic              unused_ign;
  assign bus.awready = state_q == IDLE && !reset;
  assign bus.wready  = state_q == DATA && !reset;
  assign bus.bvalid  = state_q == RESP && !reset;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign b_hs  = bus.bvalid && bus.bready;
  assign last  = cnt_q == len_q;
  // WRAP bursts advance like INCR; only FIXED holds the address
  assign addr_d = burst_q == 2'b00 ? addr_q : addr_q + ADDR_W'(4);
  assign cnt_d  = last ? cnt_q : cnt_q + 4'd1;
`ifdef AXI_WR_SLAVE_ERR_CHECK_EN
  assign aw_err    = bus.awsize != 3'b010;
  assign beat_err  = bus.wid != id_q || bus.wlast != last;
  assign bus.bresp = {err_q, 1'b0};
`else
  logic unused_chk;
  assign aw_err     = 1'b0;
  assign beat_err   = 1'b0;
  assign bus.bresp  = 2'b00;
  assign unused_chk = ^{bus.awsize, bus.wid, bus.wlast, err_q};
`endif
  assign unused_ign    = ^{bus.awlock, bus.awcache, bus.awprot};
  assign bus.ram_we    = w_hs && !(err_q || beat_err);
  assign bus.ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.ram_wdata = bus.wdata;
  assign bus.ram_sel   = bus.wstrb;
  assign bus.bid       = id_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        state_q <= DATA;
        id_q    <= bus.awid;
        addr_q  <= bus.awaddr;
        len_q   <= bus.awlen;
        burst_q <= bus.awburst;
        cnt_q   <= '0;
        err_q   <= aw_err;
      end
      if (w_hs) begin
        addr_q  <= addr_d;
        cnt_q   <= cnt_d;
        err_q   <= err_q || beat_err;
        state_q <= last ? RESP : DATA;
      end
      if (b_hs) state_q <= IDLE;
    end
  end
endmodule
